// File: rtl/popcount_window_if.sv
// Valid/ready bundle for the popcount window detector: word in, count and window flags out.
interface popcount_window_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_match;
    logic             out_below;
    logic             out_above;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, out_match, out_below, out_above
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, out_match, out_below, out_above
    );
endinterface

// File: rtl/popcount_window.sv
// Sequential k-of-N detector: counts set bits CHUNK at a time and flags whether the
// total falls inside the inclusive window [LO,HI]. All outputs are registered.
module popcount_window #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int LO    = 2,
    parameter int HI    = 3
) (
    input  logic               clk,
    input  logic               rst,
    popcount_window_if.slave   bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || LO < 0 || LO > HI || HI > WIDTH)
    begin : g_bad_params
        $error("popcount_window: illegal WIDTH/CHUNK/LO/HI combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    sum_next;

    function automatic logic [CW-1:0] chunk_ones(input logic [CHUNK-1:0] c);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CW'(c[i]);
        end
        return n;
    endfunction

    always_comb begin
        sum_next = acc + chunk_ones(sh[CHUNK-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sh            <= '0;
            acc           <= '0;
            idx           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
            bus.out_match <= 1'b0;
            bus.out_below <= 1'b0;
            bus.out_above <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh           <= bus.in_data;
                        acc          <= '0;
                        idx          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= COUNT;
                    end
                end
                COUNT: begin
                    acc <= sum_next;
                    sh  <= sh >> CHUNK;
                    idx <= idx + 1'b1;
                    // Last chunk: publish the completed sum and its window classification together.
                    if (idx == IW'(NCH - 1)) begin
                        bus.out_count <= sum_next;
                        bus.out_below <= (int'(sum_next) < LO);
                        bus.out_above <= (int'(sum_next) > HI);
                        bus.out_match <= (int'(sum_next) >= LO) && (int'(sum_next) <= HI);
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_window.sv
// Directed bench for popcount_window: default 16/4 instance plus 4/1 and 4/4 variants.
module tb_popcount_window;
    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   fails;

    popcount_window_if #(.WIDTH(16)) ia ();
    popcount_window_if #(.WIDTH(4))  ib ();
    popcount_window_if #(.WIDTH(4))  ic ();

    popcount_window #(.WIDTH(16), .CHUNK(4), .LO(2), .HI(3)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    popcount_window #(.WIDTH(4),  .CHUNK(1), .LO(2), .HI(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    popcount_window #(.WIDTH(4),  .CHUNK(4), .LO(2), .HI(3)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic v, input logic [15:0] d);
        case (sel)
            0:       begin ia.in_valid = v; ia.in_data = d;      end
            1:       begin ib.in_valid = v; ib.in_data = d[3:0]; end
            default: begin ic.in_valid = v; ic.in_data = d[3:0]; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic v, output logic [4:0] c,
                           output logic m, output logic b, output logic a, output logic r);
        case (sel)
            0: begin
                v = ia.out_valid; c = ia.out_count; m = ia.out_match;
                b = ia.out_below; a = ia.out_above; r = ia.in_ready;
            end
            1: begin
                v = ib.out_valid; c = {2'b00, ib.out_count}; m = ib.out_match;
                b = ib.out_below; a = ib.out_above; r = ib.in_ready;
            end
            default: begin
                v = ic.out_valid; c = {2'b00, ic.out_count}; m = ic.out_match;
                b = ic.out_below; a = ic.out_above; r = ic.in_ready;
            end
        endcase
    endtask

    // One full transaction with out_ready held high: accept, wait for result, handshake.
    task automatic txn(input int sel, input logic [15:0] w, input int ec, input int em,
                       input int eb, input int ea, input int elat, input string tag);
        logic v, m, b, a, r;
        logic [4:0] c;
        int lat;
        get_out(sel, v, c, m, b, a, r);
        chk({tag, "_rdy"}, 32'(r), 1);
        set_in(sel, 1'b1, w);
        tick();
        set_in(sel, 1'b0, 16'h0000);
        lat = 0;
        get_out(sel, v, c, m, b, a, r);
        while (!v && lat < 20) begin
            tick();
            lat++;
            get_out(sel, v, c, m, b, a, r);
        end
        chk({tag, "_lat"},   32'(lat), 32'(elat));
        chk({tag, "_cnt"},   32'(c),   32'(ec));
        chk({tag, "_match"}, 32'(m),   32'(em));
        chk({tag, "_below"}, 32'(b),   32'(eb));
        chk({tag, "_above"}, 32'(a),   32'(ea));
        tick();
        get_out(sel, v, c, m, b, a, r);
        chk({tag, "_vclr"},  32'(v), 0);
        chk({tag, "_rdy2"},  32'(r), 1);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] w;
        logic chg;
        int t, last, got, pc;

        checks = 0; passes = 0; fails = 0;
        rst = 1'b1;
        set_in(0, 1'b0, 16'h0000);
        set_in(1, 1'b0, 16'h0000);
        set_in(2, 1'b0, 16'h0000);
        ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_vld",   32'(ia.out_valid), 0);
        chk("rst_cnt",   32'(ia.out_count), 0);
        chk("rst_match", 32'(ia.out_match), 0);
        chk("rst_below", 32'(ia.out_below), 0);
        chk("rst_above", 32'(ia.out_above), 0);
        rst = 1'b0;
        tick();
        chk("rst_rdy", 32'(ia.in_ready), 1);

        // Basic window classification on the default instance
        txn(0, 16'h0003, 2,  1, 0, 0, 4, "t1_0003");
        txn(0, 16'h0000, 0,  0, 1, 0, 4, "t2_0000");
        txn(0, 16'hFFFF, 16, 0, 0, 1, 4, "t2_FFFF");
        txn(0, 16'h8421, 4,  0, 0, 1, 4, "t2_8421");

        // Backpressure: result held, in_valid ignored while busy
        ia.out_ready = 1'b0;
        set_in(0, 1'b1, 16'h0007);
        tick();
        set_in(0, 1'b0, 16'h0000);
        repeat (4) tick();
        chk("t3_vld",   32'(ia.out_valid), 1);
        chk("t3_cnt",   32'(ia.out_count), 3);
        chk("t3_match", 32'(ia.out_match), 1);
        for (int i = 0; i < 6; i++) begin
            set_in(0, (i % 2) == 0, 16'hFFFF);
            tick();
            chk($sformatf("t3_hold_vld[%0d]", i), 32'(ia.out_valid), 1);
            chk($sformatf("t3_hold_cnt[%0d]", i), 32'(ia.out_count), 3);
            chk($sformatf("t3_hold_rdy[%0d]", i), 32'(ia.in_ready),  0);
        end
        set_in(0, 1'b0, 16'h0000);
        ia.out_ready = 1'b1;
        tick();
        chk("t3_rel_vld", 32'(ia.out_valid), 0);
        chk("t3_rel_rdy", 32'(ia.in_ready),  1);
        chk("t3_rel_cnt", 32'(ia.out_count), 3);

        // Asynchronous reset in the second COUNT cycle
        set_in(0, 1'b1, 16'h00FF);
        tick();
        set_in(0, 1'b0, 16'h0000);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t4_vld",   32'(ia.out_valid), 0);
        chk("t4_cnt",   32'(ia.out_count), 0);
        chk("t4_match", 32'(ia.out_match), 0);
        chk("t4_below", 32'(ia.out_below), 0);
        chk("t4_above", 32'(ia.out_above), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("t4_rdy", 32'(ia.in_ready),  1);
        chk("t4_vld2", 32'(ia.out_valid), 0);
        txn(0, 16'h0101, 2, 1, 0, 0, 4, "t4_0101");

        // Narrow variants: bit-serial and single-cycle, every input word
        for (int i = 0; i < 16; i++) begin
            w  = 16'(i);
            pc = $countones(w);
            txn(1, w, pc, int'(pc >= 2 && pc <= 3), int'(pc < 2), int'(pc > 3), 4,
                $sformatf("t5b[%0d]", i));
            txn(2, w, pc, int'(pc >= 2 && pc <= 3), int'(pc < 2), int'(pc > 3), 1,
                $sformatf("t5c[%0d]", i));
        end

        // Streaming with in_valid and out_ready held: one result per NCH+2 cycles
        t = 0; last = -1; got = 0; chg = 1'b0;
        ia.in_data  = 16'($urandom);
        ia.in_valid = 1'b1;
        while (got < 5 && t < 100) begin
            if (chg) begin
                ia.in_data = 16'($urandom);
                chg = 1'b0;
            end
            if (ia.out_valid) begin
                if (q.size() > 0) w = q.pop_front();
                else w = 16'h0000;
                chk($sformatf("t6_cnt[%0d]", got), 32'(ia.out_count), 32'($countones(w)));
                if (last >= 0) chk($sformatf("t6_period[%0d]", got), 32'(t - last), 6);
                last = t;
                got++;
            end
            if (ia.in_ready) begin
                q.push_back(ia.in_data);
                chg = 1'b1;
            end
            tick();
            t++;
        end
        ia.in_valid = 1'b0;
        chk("t6_results", 32'(got), 5);
        repeat (10) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
